fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] SHALL be zero.
REQ-002 Port: clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: ip_stall  input  1  load-to-use stall request from the stall controller.
REQ-005 Port: ip_redirect  input  1  taken-branch redirect from the branch-resolve stage.
REQ-006 Port: ip_redirect_target  input  32  branch target address.
REQ-007 Port: op_imem_addr  output  32  instruction-memory address; equals current PC, combinational from the PC register.
REQ-008 Port: ip_imem_data  input  32  instruction word; combinationally valid for op_imem_addr in the same cycle.
REQ-009 Port: op_instruction  output  32  IF/ID instruction register; feeds decode and the stall controller.
REQ-010 Port: op_pc_plus4  output  32  IF/ID PC+4 register.
REQ-011 Port: op_valid  output  1  IF/ID holds a real fetched instruction, not a bubble.
REQ-012 Port: op_stall_cycles  output  32  saturating count of stall-hold cycles.
REQ-013 Port: op_flush_count  output  32  saturating count of redirects.

Function
REQ-014 Per-edge priority SHALL be: reset > redirect > stall > normal advance.
REQ-015 Normal advance: PC <= PC+4; op_instruction <= ip_imem_data; op_pc_plus4 <= PC+4; op_valid <= 1.
REQ-016 Stall (ip_stall=1, ip_redirect=0): PC, op_instruction, op_pc_plus4 and op_valid SHALL hold; op_stall_cycles SHALL increment.
REQ-017 Redirect: PC <= {ip_redirect_target[31:2],2'b00}; op_instruction <= NOP (32'h0000_0000); op_pc_plus4 <= 0; op_valid <= 0; op_flush_count SHALL increment.
REQ-018 Redirect and stall asserted together: redirect SHALL win and the stall cycle SHALL NOT be counted.
REQ-019 PC+4 arithmetic SHALL be 32-bit modulo; PC 32'hFFFF_FFFC SHALL advance to 32'h0000_0000.
REQ-020 The fetched instruction SHALL reach op_instruction exactly one cycle after op_imem_addr presents its address, absent stall or redirect.
REQ-021 Counters SHALL saturate at 32'hFFFF_FFFF and never wrap.
REQ-022 Consecutive stall cycles SHALL be unlimited; advance resumes on the first edge with ip_stall=0.
REQ-023 A bubble (op_valid=0) SHALL carry NOP so downstream RegWrite decodes to 0.

Reset
REQ-024 On reset: PC <= RESET_PC; op_instruction <= NOP; op_pc_plus4 <= 0; op_valid <= 0; both counters <= 0.
REQ-025 Reset asserted mid-stall or mid-redirect SHALL override both; the first post-reset fetch SHALL be from RESET_PC.

Structure
REQ-026 A shared package mips_pkg SHALL hold the NOP constant, the 32-bit word width, and the default RESET_PC.
REQ-027 One sub-module, sat_counter (32-bit, increment-enable, synchronous clear), SHALL be instantiated twice for the two counters.

Verification
REQ-028 Reset, then 4 free-running cycles with imem returning 32'h2000_0001+addr -> op_imem_addr 0,4,8,C; op_instruction lags by one cycle; op_valid=1 from cycle 2.
REQ-029 ip_stall=1 for 3 cycles at PC=8 -> PC holds 8, op_instruction holds, op_stall_cycles=3; advance resumes at PC=C.
REQ-030 ip_redirect=1, target 32'h0000_0043, same cycle as ip_stall=1 -> PC=32'h40, op_instruction=0, op_valid=0, op_flush_count=1, op_stall_cycles unchanged.
REQ-031 PC forced to 32'hFFFF_FFFC via redirect, then one advance -> PC=0, op_pc_plus4=0.
REQ-032 Reset asserted during a stall with op_stall_cycles=5 -> next edge PC=RESET_PC, op_valid=0, counters=0.
REQ-033 Counter preloaded (via hierarchical force) to 32'hFFFF_FFFE, then 3 stall cycles -> op_stall_cycles=32'hFFFF_FFFF.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS fetch path: word width, NOP encoding, reset PC.
package mips_pkg;
  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP = 32'h0000_0000;
  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/sat_counter.sv
// Increment-enable counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              inc_en,
  output logic [DATA_W-1:0] count
);

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] val);
    return (&val) ? val : val + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc_en) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, IF/ID pipeline register, stall and flush counters.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ip_stall,
  input  logic        ip_redirect,
  input  logic [31:0] ip_redirect_target,
  output logic [31:0] op_imem_addr,
  input  logic [31:0] ip_imem_data,
  output logic [31:0] op_instruction,
  output logic [31:0] op_pc_plus4,
  output logic        op_valid,
  output logic [31:0] op_stall_cycles,
  output logic [31:0] op_flush_count
);

  logic [WORD_W-1:0] pc_p0;
  logic [WORD_W-1:0] pc_next_p0;
  logic [WORD_W-1:0] instr_p1;
  logic [WORD_W-1:0] pc_plus4_p1;
  logic              vld_p1;
  logic              stall_hold;

  // Fetch: modulo-2^32 sequential address; redirect beats stall
  assign pc_next_p0   = pc_p0 + 32'd4;
  assign op_imem_addr = pc_p0;
  assign stall_hold   = ip_stall & ~ip_redirect;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_p0       <= RESET_PC;
      instr_p1    <= NOP;
      pc_plus4_p1 <= '0;
      vld_p1      <= 1'b0;
    end else if (ip_redirect) begin
      pc_p0       <= {ip_redirect_target[31:2], 2'b00};
      instr_p1    <= NOP;
      pc_plus4_p1 <= '0;
      vld_p1      <= 1'b0;
    end else if (!ip_stall) begin
      pc_p0       <= pc_next_p0;
      instr_p1    <= ip_imem_data;
      pc_plus4_p1 <= pc_next_p0;
      vld_p1      <= 1'b1;
    end
  end

  // IF/ID boundary
  assign op_instruction = instr_p1;
  assign op_pc_plus4    = pc_plus4_p1;
  assign op_valid       = vld_p1;

  sat_counter #(.DATA_W(WORD_W)) u_stall_cnt (
    .clk    (clock),
    .clear  (reset),
    .inc_en (stall_hold),
    .count  (op_stall_cycles)
  );

  sat_counter #(.DATA_W(WORD_W)) u_flush_cnt (
    .clk    (clock),
    .clear  (reset),
    .inc_en (ip_redirect),
    .count  (op_flush_count)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a reference model pushes expected state per edge.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ip_stall = 1'b0;
  logic        ip_redirect = 1'b0;
  logic [31:0] ip_redirect_target = '0;
  logic [31:0] op_imem_addr;
  logic [31:0] ip_imem_data;
  logic [31:0] op_instruction;
  logic [31:0] op_pc_plus4;
  logic        op_valid;
  logic [31:0] op_stall_cycles;
  logic [31:0] op_flush_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
    logic [31:0] stalls;
    logic [31:0] flushes;
  } state_t;

  state_t model;
  state_t exp_q[$];

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clock              (clock),
    .reset              (reset),
    .ip_stall           (ip_stall),
    .ip_redirect        (ip_redirect),
    .ip_redirect_target (ip_redirect_target),
    .op_imem_addr       (op_imem_addr),
    .ip_imem_data       (ip_imem_data),
    .op_instruction     (op_instruction),
    .op_pc_plus4        (op_pc_plus4),
    .op_valid           (op_valid),
    .op_stall_cycles    (op_stall_cycles),
    .op_flush_count     (op_flush_count)
  );

  always #5 clock = ~clock;

  assign ip_imem_data = 32'h2000_0001 + op_imem_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat1(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Drive one cycle, predict the post-edge state, then compare after the edge.
  task automatic step(input logic rst, input logic stall, input logic redir,
                      input logic [31:0] tgt);
    state_t e;
    @(negedge clock);
    reset = rst;
    ip_stall = stall;
    ip_redirect = redir;
    ip_redirect_target = tgt;
    check("imem_addr", op_imem_addr, model.pc);
    e = model;
    if (rst) begin
      e.pc = 32'h0; e.instr = 32'h0; e.pc_plus4 = 32'h0; e.valid = 1'b0;
      e.stalls = 32'h0; e.flushes = 32'h0;
    end else if (redir) begin
      e.pc = {tgt[31:2], 2'b00}; e.instr = 32'h0; e.pc_plus4 = 32'h0; e.valid = 1'b0;
      e.flushes = sat1(model.flushes);
    end else if (stall) begin
      e.stalls = sat1(model.stalls);
    end else begin
      e.instr = 32'h2000_0001 + model.pc;
      e.pc = model.pc + 32'd4;
      e.pc_plus4 = e.pc;
      e.valid = 1'b1;
    end
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check("pc", op_imem_addr, e.pc);
    check("instruction", op_instruction, e.instr);
    check("pc_plus4", op_pc_plus4, e.pc_plus4);
    check("valid", {31'b0, op_valid}, {31'b0, e.valid});
    check("stall_cycles", op_stall_cycles, e.stalls);
    check("flush_count", op_flush_count, e.flushes);
    model = e;
  endtask

  initial begin
    model = '{pc: 32'h0, instr: 32'h0, pc_plus4: 32'h0, valid: 1'b0, stalls: 32'h0, flushes: 32'h0};

    // Reset and free-running fetch
    step(1, 0, 0, 0);
    check("rst_pc", op_imem_addr, 32'h0);
    check("rst_valid", {31'b0, op_valid}, 32'h0);
    step(0, 0, 0, 0);
    check("adv1_instr", op_instruction, 32'h2000_0001);
    check("adv1_valid", {31'b0, op_valid}, 32'h1);
    step(0, 0, 0, 0);
    check("adv2_pc", op_imem_addr, 32'h8);
    check("adv2_instr", op_instruction, 32'h2000_0005);

    // Three stalls at PC=8
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    check("stall_pc", op_imem_addr, 32'h8);
    check("stall_instr", op_instruction, 32'h2000_0005);
    check("stall_cnt3", op_stall_cycles, 32'd3);
    step(0, 0, 0, 0);
    check("resume_pc", op_imem_addr, 32'hC);
    check("resume_instr", op_instruction, 32'h2000_0009);
    step(0, 0, 0, 0);

    // Redirect wins over stall
    step(0, 1, 1, 32'h0000_0043);
    check("redir_pc", op_imem_addr, 32'h40);
    check("redir_instr", op_instruction, 32'h0);
    check("redir_flush", op_flush_count, 32'd1);
    check("redir_stalls", op_stall_cycles, 32'd3);
    step(0, 0, 0, 0);

    // PC wrap at the top of the address space
    step(0, 0, 1, 32'hFFFF_FFFF);
    check("wrap_setup_pc", op_imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    check("wrap_pc", op_imem_addr, 32'h0);
    check("wrap_pc4", op_pc_plus4, 32'h0);

    // Reset during a stall with 5 stall cycles counted
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    check("pre_rst_stalls", op_stall_cycles, 32'd5);
    step(1, 1, 0, 0);
    check("midstall_rst_cnt", op_stall_cycles, 32'h0);
    check("midstall_rst_flush", op_flush_count, 32'h0);
    step(0, 0, 0, 0);
    check("post_rst_instr", op_instruction, 32'h2000_0001);

    // Random mix of advance, stall and redirect
    for (int i = 0; i < 40; i++) begin
      logic s, r;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 7) == 0);
      step(0, s, r, $urandom);
    end

    // Counter saturation from a forced near-max value
    force dut.u_stall_cnt.count = 32'hFFFF_FFFE;
    #1;
    release dut.u_stall_cnt.count;
    model.stalls = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    check("sat_stalls", op_stall_cycles, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
